addnu_loa_pipe: RTL and testbench
=================================

// Module: addNu_loa_pipe
// PURPOSE
//   Parametrised unsigned approximate adder, successor to the fixed 8-bit combinational adders.
//   Sum = WIDTH+1 bits. The low APPROX_BITS use a lower-part-OR (LOA) scheme; mode is selectable per transaction.
//   The carry chain is split into STAGES registered segments, with a valid/ready handshake.
//   Each result is checked against the exact sum, and a saturating error counter feeds the error-characterisation harness.
// PARAMETERS
//   WIDTH        8   operand width, >=2
//   APPROX_BITS  3   number of low bits approximated in approx mode, 0..WIDTH
//   STAGES       2   pipeline depth/latency, 1..WIDTH; segment width = ceil(WIDTH/STAGES), last segment takes remainder
//   CNT_W        16  width of err_cnt
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        operands valid
//   in_ready   out  1        block can accept operands this cycle
//   in_a       in   WIDTH    operand A
//   in_b       in   WIDTH    operand B
//   in_approx  in   1        1 = approximate mode, 0 = exact; sampled with operands
//   out_valid  out  1        result valid
//   out_ready  in   1        downstream accepts result
//   out_sum    out  WIDTH+1  result
//   out_diff   out  1        out_sum differs from exact A+B for this transaction
//   err_cnt    out  CNT_W    count of accepted results with out_diff=1, saturating
//   cnt_clr    in   1        synchronous clear of err_cnt
// BEHAVIOUR
//   Reset (async, rst_n=0): all stage valids=0, out_valid=0, out_sum=0, out_diff=0, err_cnt=0; in-flight data discarded.
//   Handshake and pipeline:
//   - Transfer on in_valid&in_ready, or on out_valid&out_ready.
//   - Global stall: advance = !out_valid | out_ready; in_ready = advance.
//   - When stalled, all stages hold and outputs are stable. Bubbles are not compressed.
//   - Latency is exactly STAGES cycles from input transfer to out_valid with no stall.
//   - Order is preserved and nothing is lost or duplicated.
//   - in_approx, operands and partial sums travel with their transaction; changing in_approx never affects in-flight data.
//   Arithmetic, with K=APPROX_BITS:
//   - Exact mode: out_sum = A+B (WIDTH+1 bits, MSB = carry out).
//   - Approx mode, K>0:
//     - out_sum[K-1:0] = A[K-1:0] | B[K-1:0]
//     - carry into bit K = A[K-1] & B[K-1]
//     - bits WIDTH:K = A[W-1:K] + B[W-1:K] + that carry
//   - K=WIDTH: no upper part; out_sum[WIDTH] = A[W-1]&B[W-1].
//   - K=0: approx mode is identical to exact and out_diff is always 0.
//   - Segment s adds its bit slice with the registered carry from segment s-1.
//   - Operand bits of later segments are delayed with the transaction.
//   - An exact reference sum is computed in the same pipeline.
//   - out_diff = approx result != reference; always 0 in exact mode.
//   err_cnt:
//   - Increments when out_valid&out_ready&out_diff; holds at 2^CNT_W-1.
//   - cnt_clr=1 sets it to 0 next cycle. Clear wins over a simultaneous increment.
//   Stall boundary: with out_valid=1 and out_ready=0, in_ready=0 even if earlier stages are empty.
// TESTING (WIDTH=8, APPROX_BITS=3, STAGES=2 unless stated)
//   1 Exact: A=200,B=100,approx=0 -> out_sum=9'h12C two cycles after accept, out_diff=0, err_cnt unchanged.
//   2 Approx, no low carry: A=8'h07,B=8'h01,approx=1 -> out_sum=9'h007, out_diff=1, err_cnt +1 on accept.
//   3 Approx, max: A=B=8'hFF,approx=1 -> out_sum=9'h1FF (exact 9'h1FE), out_diff=1.
//     Same operands with approx=0 -> 9'h1FE, out_diff=0.
//   4 Backpressure: 3 back-to-back inputs, out_ready=0 for 5 cycles, then 1.
//     -> in_ready=0 while out_valid&!out_ready; outputs stable while held.
//     -> 3 results in order, none lost or duplicated.
//   5 Counter: CNT_W=4, 20 differing approx adds -> err_cnt=15.
//     cnt_clr on the same cycle as a differing accept -> err_cnt=0.
//   6 Reset mid-flight: rst_n low for 1 cycle with 2 transactions in flight.
//     -> out_valid=0 and err_cnt=0 immediately; first output after release comes from a post-reset input.
//     Also: random sweep over parameter sets (8,0,1),(8,8,8),(16,5,3) vs a scoreboard model.

Source files
------------

// File: rtl/addnu_loa_pipe.sv
// -----------------------------------------------------------------------------
// addnu_loa_pipe
//   Parametrised unsigned approximate adder with a lower-part-OR (LOA) low
//   section and a carry chain split across STAGES registered segments.
//   Each transaction carries its own mode bit. An exact reference sum is
//   computed in the same pipeline, so every result is flagged when the
//   approximation changed it. A saturating counter tallies those results.
//
//   Parameters
//     WIDTH        operand width (>= 2)
//     APPROX_BITS  low bits approximated in approx mode (0..WIDTH)
//     STAGES       pipeline depth and latency (1..WIDTH)
//     CNT_W        width of err_cnt
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   operands valid
//     in_ready   block accepts operands this cycle
//     in_a/in_b  operands, WIDTH bits
//     in_approx  1 = approximate, 0 = exact; travels with the operands
//     out_valid  result valid
//     out_ready  downstream accepts the result
//     out_sum    WIDTH+1 bit result, MSB is the carry out
//     out_diff   out_sum differs from the exact A+B of this transaction
//     err_cnt    saturating count of accepted results with out_diff = 1
//     cnt_clr    synchronous clear of err_cnt, wins over an increment
// -----------------------------------------------------------------------------
module addnu_loa_pipe #(
   parameter int WIDTH       = 8,
   parameter int APPROX_BITS = 3,
   parameter int STAGES      = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_approx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_sum,
   output logic             out_diff,
   output logic [CNT_W-1:0] err_cnt,
   input  logic             cnt_clr
);

   // Segment width rounds up; trailing segments may be short or even empty
   // (an empty segment just forwards its carry and still costs one cycle).
   localparam int SEG  = (WIDTH + STAGES - 1) / STAGES;
   localparam int LAST = STAGES - 1;

   // Whole pipe moves together: a stalled output freezes every stage, so no
   // bubble is ever squeezed out and in_ready drops even with empty stages.
   logic advance;

   logic             v_reg    [STAGES];
   logic             mode_reg [STAGES];
   logic [WIDTH-1:0] a_reg    [STAGES];
   logic [WIDTH-1:0] b_reg    [STAGES];
   logic [WIDTH-1:0] res_reg  [STAGES];   // result bits produced so far
   logic [WIDTH-1:0] ref_reg  [STAGES];   // exact reference bits so far
   logic             cr_reg   [STAGES];   // result carry out of the segment
   logic             ce_reg   [STAGES];   // reference carry out of the segment

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         localparam int LO = (gi * SEG < WIDTH) ? gi * SEG : WIDTH;
         localparam int HI = ((gi + 1) * SEG < WIDTH) ? (gi + 1) * SEG : WIDTH;

         logic             src_v;
         logic             src_mode;
         logic [WIDTH-1:0] src_a;
         logic [WIDTH-1:0] src_b;
         logic [WIDTH-1:0] src_res;
         logic [WIDTH-1:0] src_ref;
         logic             src_cr;
         logic             src_ce;

         logic [WIDTH-1:0] res_next;
         logic [WIDTH-1:0] ref_next;
         logic             cr_next;
         logic             ce_next;

         if (gi == 0) begin : g_src_in
            assign src_v    = in_valid;
            assign src_mode = in_approx;
            assign src_a    = in_a;
            assign src_b    = in_b;
            assign src_res  = '0;
            assign src_ref  = '0;
            assign src_cr   = 1'b0;
            assign src_ce   = 1'b0;
         end else begin : g_src_prev
            assign src_v    = v_reg[gi-1];
            assign src_mode = mode_reg[gi-1];
            assign src_a    = a_reg[gi-1];
            assign src_b    = b_reg[gi-1];
            assign src_res  = res_reg[gi-1];
            assign src_ref  = ref_reg[gi-1];
            assign src_cr   = cr_reg[gi-1];
            assign src_ce   = ce_reg[gi-1];
         end

         // Ripple through this segment's bit slice. Below APPROX_BITS in
         // approx mode each bit is a plain OR; the only carry leaving the
         // low part is the AND of its top bit pair, injected at bit K.
         always_comb begin
            res_next = src_res;
            ref_next = src_ref;
            cr_next  = src_cr;
            ce_next  = src_ce;
            for (int i = 0; i < WIDTH; i++) begin
               if (i >= LO && i < HI) begin
                  ref_next[i] = src_a[i] ^ src_b[i] ^ ce_next;
                  ce_next     = (src_a[i] & src_b[i]) | (ce_next & (src_a[i] ^ src_b[i]));
                  if (src_mode && i < APPROX_BITS) begin
                     res_next[i] = src_a[i] | src_b[i];
                     cr_next     = (i == APPROX_BITS - 1) ? (src_a[i] & src_b[i]) : 1'b0;
                  end else begin
                     res_next[i] = src_a[i] ^ src_b[i] ^ cr_next;
                     cr_next     = (src_a[i] & src_b[i]) | (cr_next & (src_a[i] ^ src_b[i]));
                  end
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v_reg[gi]    <= 1'b0;
               mode_reg[gi] <= 1'b0;
               a_reg[gi]    <= '0;
               b_reg[gi]    <= '0;
               res_reg[gi]  <= '0;
               ref_reg[gi]  <= '0;
               cr_reg[gi]   <= 1'b0;
               ce_reg[gi]   <= 1'b0;
            end else if (advance) begin
               v_reg[gi]    <= src_v;
               mode_reg[gi] <= src_mode;
               a_reg[gi]    <= src_a;
               b_reg[gi]    <= src_b;
               res_reg[gi]  <= res_next;
               ref_reg[gi]  <= ref_next;
               cr_reg[gi]   <= cr_next;
               ce_reg[gi]   <= ce_next;
            end
         end
      end
   endgenerate

   assign out_valid = v_reg[LAST];
   assign out_sum   = {cr_reg[LAST], res_reg[LAST]};
   // Exact-mode results equal the reference by construction; the mode gate
   // keeps the flag quiet regardless.
   assign out_diff  = mode_reg[LAST] &&
                      ({cr_reg[LAST], res_reg[LAST]} != {ce_reg[LAST], ref_reg[LAST]});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (cnt_clr) begin
         err_cnt <= '0;
      end else if (out_valid && out_ready && out_diff && (err_cnt != {CNT_W{1'b1}})) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_addnu_loa_pipe.sv
// -----------------------------------------------------------------------------
// tb_addnu_loa_pipe
//   Directed tests on an (8,3,2) instance, a counter test on a CNT_W=4
//   instance, and a randomized handshake sweep over (8,0,1), (8,8,8) and
//   (16,5,3) instances against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_addnu_loa_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // LOA sum from the arithmetic definition: OR the low K bits, carry the
   // AND of bit K-1 into an ordinary add of the upper parts.
   function automatic logic [31:0] ref_sum(input int k, input logic [31:0] a,
                                           input logic [31:0] b, input logic m);
      logic [31:0] low, c, up;
      if (!m || k == 0) return a + b;
      low = (a | b) & ((32'd1 << k) - 32'd1);
      c   = (a >> (k - 1)) & (b >> (k - 1)) & 32'd1;
      up  = (a >> k) + (b >> k) + c;
      return (up << k) | low;
   endfunction

   // ---------------- main instance (8,3,2,16) ----------------
   logic       m_iv, m_ir, m_am, m_ov, m_or, m_diff, m_clr;
   logic [7:0] m_a, m_b;
   logic [8:0] m_sum;
   logic [15:0] m_cnt;
   int         m_exp;

   addnu_loa_pipe #(.WIDTH(8), .APPROX_BITS(3), .STAGES(2), .CNT_W(16)) u_main (
      .clk(clk), .rst_n(rst_n), .in_valid(m_iv), .in_ready(m_ir), .in_a(m_a), .in_b(m_b),
      .in_approx(m_am), .out_valid(m_ov), .out_ready(m_or), .out_sum(m_sum),
      .out_diff(m_diff), .err_cnt(m_cnt), .cnt_clr(m_clr));

   // ---------------- counter instance (8,3,2,4) ----------------
   logic       c_iv, c_ir, c_am, c_ov, c_or, c_diff, c_clr;
   logic [7:0] c_a, c_b;
   logic [8:0] c_sum;
   logic [3:0] c_cnt;

   addnu_loa_pipe #(.WIDTH(8), .APPROX_BITS(3), .STAGES(2), .CNT_W(4)) u_cnt (
      .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in_a(c_a), .in_b(c_b),
      .in_approx(c_am), .out_valid(c_ov), .out_ready(c_or), .out_sum(c_sum),
      .out_diff(c_diff), .err_cnt(c_cnt), .cnt_clr(c_clr));

   // ---------------- sweep instances ----------------
   localparam int SW_K [3] = '{0, 8, 5};
   localparam int SW_W [3] = '{8, 8, 16};

   logic        sw_iv [3];
   logic        sw_am [3];
   logic        sw_or [3];
   logic [15:0] sw_a  [3];
   logic [15:0] sw_b  [3];
   logic        sw_clr;
   logic        acc   [3];
   logic [17:0] sq    [3][$];
   int          sw_exp_err [3];

   logic        s0_ir, s0_ov, s0_diff, s1_ir, s1_ov, s1_diff, s2_ir, s2_ov, s2_diff;
   logic [8:0]  s0_sum, s1_sum;
   logic [16:0] s2_sum;
   logic [15:0] s0_cnt, s1_cnt, s2_cnt;

   addnu_loa_pipe #(.WIDTH(8), .APPROX_BITS(0), .STAGES(1), .CNT_W(16)) u_s0 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[0]), .in_ready(s0_ir), .in_a(sw_a[0][7:0]),
      .in_b(sw_b[0][7:0]), .in_approx(sw_am[0]), .out_valid(s0_ov), .out_ready(sw_or[0]),
      .out_sum(s0_sum), .out_diff(s0_diff), .err_cnt(s0_cnt), .cnt_clr(sw_clr));

   addnu_loa_pipe #(.WIDTH(8), .APPROX_BITS(8), .STAGES(8), .CNT_W(16)) u_s1 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[1]), .in_ready(s1_ir), .in_a(sw_a[1][7:0]),
      .in_b(sw_b[1][7:0]), .in_approx(sw_am[1]), .out_valid(s1_ov), .out_ready(sw_or[1]),
      .out_sum(s1_sum), .out_diff(s1_diff), .err_cnt(s1_cnt), .cnt_clr(sw_clr));

   addnu_loa_pipe #(.WIDTH(16), .APPROX_BITS(5), .STAGES(3), .CNT_W(16)) u_s2 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[2]), .in_ready(s2_ir), .in_a(sw_a[2]),
      .in_b(sw_b[2]), .in_approx(sw_am[2]), .out_valid(s2_ov), .out_ready(sw_or[2]),
      .out_sum(s2_sum), .out_diff(s2_diff), .err_cnt(s2_cnt), .cnt_clr(sw_clr));

   // One isolated transaction on the main instance, checking exact latency.
   task automatic one_shot(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic m, input logic [8:0] es, input logic ed);
      @(negedge clk);
      m_iv = 1'b1; m_a = a; m_b = b; m_am = m; m_or = 1'b1;
      #1 check_val({tag, "_inready"}, 32'(m_ir), 32'd1);
      @(negedge clk);
      m_iv = 1'b0; m_am = ~m;   // mode flip must not reach the in-flight add
      check_val({tag, "_lat1"}, 32'(m_ov), 32'd0);
      @(negedge clk);
      check_val({tag, "_valid"}, 32'(m_ov), 32'd1);
      check_val({tag, "_sum"}, 32'(m_sum), 32'(es));
      check_val({tag, "_diff"}, 32'(m_diff), 32'(ed));
      $display("txn %s a=%0h b=%0h approx=%0d sum=%0h diff=%0d", tag, a, b, m, m_sum, m_diff);
      @(negedge clk);
      if (ed) m_exp++;
      check_val({tag, "_cnt"}, 32'(m_cnt), 32'(m_exp));
   endtask

   task automatic sweep_cycle(input bit allow_new);
      logic        ov [3];
      logic        ir [3];
      logic        df [3];
      logic [16:0] sm [3];
      logic [31:0] es, mask;
      logic [17:0] e;
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
         mask = (32'd1 << SW_W[j]) - 32'd1;
         if (!allow_new) begin
            sw_iv[j] = 1'b0;
         end else if (!sw_iv[j] || acc[j]) begin
            sw_iv[j] = ($urandom_range(0, 3) != 0);
            sw_a[j]  = 16'($urandom & mask);
            sw_b[j]  = 16'($urandom & mask);
            sw_am[j] = 1'($urandom_range(0, 1));
         end
         sw_or[j] = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      #1;
      ov = '{s0_ov, s1_ov, s2_ov};
      ir = '{s0_ir, s1_ir, s2_ir};
      df = '{s0_diff, s1_diff, s2_diff};
      sm = '{{8'b0, s0_sum}, {8'b0, s1_sum}, s2_sum};
      for (int j = 0; j < 3; j++) begin
         if (ov[j] && sw_or[j]) begin
            if (sq[j].size() == 0) begin
               check_val($sformatf("sw%0d_spurious", j), 32'd1, 32'd0);
            end else begin
               e = sq[j].pop_front();
               check_val($sformatf("sw%0d_sum", j), 32'(sm[j]), 32'(e[16:0]));
               check_val($sformatf("sw%0d_diff", j), 32'(df[j]), 32'(e[17]));
               if (e[17]) sw_exp_err[j]++;
               $display("txn sw%0d sum=%0h diff=%0d", j, sm[j], df[j]);
            end
         end
         acc[j] = sw_iv[j] && ir[j];
         if (acc[j]) begin
            es = ref_sum(SW_K[j], 32'(sw_a[j]), 32'(sw_b[j]), sw_am[j]);
            sq[j].push_back({(es != 32'(sw_a[j]) + 32'(sw_b[j])), es[16:0]});
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout reached");
      $fatal(1);
   end

   initial begin
      logic [8:0]  mq [$];
      logic [8:0]  e9, prev_sum;
      logic [31:0] es;
      bit          held_prev, seen;
      int          sent, got, seen_cyc;

      rst_n = 1'b0;
      m_iv = 0; m_a = 0; m_b = 0; m_am = 0; m_or = 0; m_clr = 0; m_exp = 0;
      c_iv = 0; c_a = 0; c_b = 0; c_am = 0; c_or = 0; c_clr = 0;
      sw_clr = 1'b0;
      for (int j = 0; j < 3; j++) begin
         sw_iv[j] = 0; sw_am[j] = 0; sw_or[j] = 0; sw_a[j] = 0; sw_b[j] = 0;
         acc[j] = 1'b1; sw_exp_err[j] = 0;
      end
      repeat (2) @(negedge clk);
      check_val("rst_out_valid", 32'(m_ov), 32'd0);
      check_val("rst_out_sum", 32'(m_sum), 32'd0);
      check_val("rst_out_diff", 32'(m_diff), 32'd0);
      check_val("rst_err_cnt", 32'(m_cnt), 32'd0);
      rst_n = 1'b1;

      // Directed arithmetic cases
      one_shot("exact", 8'd200, 8'd100, 1'b0, 9'h12C, 1'b0);
      one_shot("nolow", 8'h07, 8'h01, 1'b1, 9'h007, 1'b1);
      one_shot("maxap", 8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b1);
      one_shot("maxex", 8'hFF, 8'hFF, 1'b0, 9'h1FE, 1'b0);

      // Backpressure: three inputs, output held for five cycles
      sent = 0; got = 0; held_prev = 0; prev_sum = 0;
      for (int cyc = 0; cyc < 25; cyc++) begin
         @(negedge clk);
         m_or = (cyc >= 7);
         if (!m_iv || m_ir) begin
            m_iv = (sent < 3);
            m_a  = 8'($urandom); m_b = 8'($urandom); m_am = 1'($urandom_range(0, 1));
         end
         #1;
         if (held_prev) begin
            check_val("bp_hold_valid", 32'(m_ov), 32'd1);
            check_val("bp_hold_sum", 32'(m_sum), 32'(prev_sum));
         end
         if (m_ov && m_or) begin
            if (mq.size() == 0) begin
               check_val("bp_spurious", 32'd1, 32'd0);
            end else begin
               e9 = mq.pop_front();
               check_val("bp_sum", 32'(m_sum), 32'(e9));
               got++;
               $display("txn bp sum=%0h diff=%0d", m_sum, m_diff);
            end
         end
         if (m_ov && !m_or) begin
            check_val("bp_in_ready", 32'(m_ir), 32'd0);
            held_prev = 1; prev_sum = m_sum;
         end else begin
            held_prev = 0;
         end
         if (m_iv && m_ir) begin
            es = ref_sum(3, 32'(m_a), 32'(m_b), m_am);
            mq.push_back(es[8:0]);
            if (es != 32'(m_a) + 32'(m_b)) m_exp++;
            sent++;
         end
      end
      m_iv = 1'b0;
      check_val("bp_sent", 32'(sent), 32'd3);
      check_val("bp_got", 32'(got), 32'd3);
      check_val("bp_cnt", 32'(m_cnt), 32'(m_exp));

      // Counter saturation and clear priority on the CNT_W=4 instance
      c_or = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         c_iv = 1'b1; c_am = 1'b1;
         c_a  = 8'(($urandom & 32'hF8) | 32'h7);
         c_b  = 8'(($urandom & 32'hF8) | 32'h1);
      end
      @(negedge clk);
      c_iv = 1'b0;
      repeat (3) @(negedge clk);
      check_val("cnt_sat", 32'(c_cnt), 32'd15);
      c_iv = 1'b1; c_am = 1'b1; c_a = 8'h07; c_b = 8'h01;
      @(negedge clk);
      c_iv = 1'b0;
      @(negedge clk);
      c_clr = 1'b1;
      #1;
      check_val("clr_pre_valid", 32'(c_ov), 32'd1);
      check_val("clr_pre_diff", 32'(c_diff), 32'd1);
      @(negedge clk);
      c_clr = 1'b0;
      check_val("clr_wins", 32'(c_cnt), 32'd0);

      // Reset with two transactions in flight
      m_or = 1'b1;
      @(negedge clk);
      m_iv = 1'b1; m_am = 1'b1; m_a = 8'h07; m_b = 8'h01;
      @(negedge clk);
      m_a = 8'h0F; m_b = 8'h09;
      @(negedge clk);
      m_iv = 1'b0;
      rst_n = 1'b0;
      #1;
      check_val("midrst_valid", 32'(m_ov), 32'd0);
      check_val("midrst_cnt", 32'(m_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; m_exp = 0;
      @(negedge clk);
      m_iv = 1'b1; m_am = 1'b0; m_a = 8'h55; m_b = 8'h22;
      seen = 0; seen_cyc = 0;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         @(negedge clk);
         m_iv = 1'b0;
         if (m_ov && !seen) begin
            seen = 1; seen_cyc = cyc;
            check_val("postrst_sum", 32'(m_sum), 32'h077);
            $display("txn postrst sum=%0h", m_sum);
         end
      end
      check_val("postrst_seen", 32'(seen), 32'd1);
      check_val("postrst_latency", 32'(seen_cyc), 32'd2);

      // Randomized sweep across parameter sets
      for (int n = 0; n < 300; n++) sweep_cycle(1'b1);
      for (int n = 0; n < 20; n++) sweep_cycle(1'b0);
      for (int j = 0; j < 3; j++)
         check_val($sformatf("sw%0d_drained", j), 32'(sq[j].size()), 32'd0);
      check_val("sw0_cnt", 32'(s0_cnt), 32'(sw_exp_err[0]));
      check_val("sw1_cnt", 32'(s1_cnt), 32'(sw_exp_err[1]));
      check_val("sw2_cnt", 32'(s2_cnt), 32'(sw_exp_err[2]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
